// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request at a time, holds the fetched
// word for the decoder until it is consumed, and follows redirects from branch logic.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] iaddr,
    output logic        ireq,
    input  logic [31:0] irdata,
    input  logic        ivalid,
    output logic [31:0] idata,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        advance,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        misaligned
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ISSUE = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_next;
    logic [31:0] idata_q;
    logic        squash;
    logic        squash_next;
    logic        capture;
    logic [31:0] target;

    assign target = {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        squash_next   = squash;
        capture       = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_REQ;
                if (redirect) fetch_pc_next = target;
            end
            S_REQ: begin
                state_next = S_WAIT;
                if (redirect) begin
                    fetch_pc_next = target;
                    squash_next   = 1'b1;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    fetch_pc_next = target;
                    squash_next   = 1'b1;
                end
                // A response racing a redirect is stale even if squash was not yet set.
                if (ivalid) begin
                    if (squash || redirect) begin
                        squash_next = 1'b0;
                        state_next  = S_REQ;
                    end else begin
                        capture    = 1'b1;
                        state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (redirect) begin
                    fetch_pc_next = target;
                    state_next    = S_REQ;
                end else if (advance) begin
                    fetch_pc_next = pc + 32'd4;
                    state_next    = S_REQ;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            fetch_pc   <= RESET_PC;
            pc         <= RESET_PC;
            idata_q    <= 32'h0;
            squash     <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            squash   <= squash_next;
            if (capture) begin
                idata_q <= irdata;
                pc      <= fetch_pc;
            end
            if (redirect && (redirect_pc[1:0] != 2'b00)) misaligned <= 1'b1;
        end
    end

    assign ireq        = (state == S_REQ);
    assign iaddr       = fetch_pc;
    assign instr_valid = (state == S_ISSUE);
    assign idata       = instr_valid ? idata_q : 32'h0;

endmodule
